// File: rtl/imem_loader_if.sv
// Loader-side bus: processor fetch port, byte-stream input, load control and status.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [31:0]       pc;
  logic [31:0]       instr;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output load_start, load_len, rx_valid, rx_data, pc,
    input  rx_ready, instr, cpu_reset, busy, done, err
  );

  modport slave (
    input  load_start, load_len, rx_valid, rx_data, pc,
    output rx_ready, instr, cpu_reset, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: fills a word memory from a big-endian byte
// stream, holds the processor in reset while loading, then releases it.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int unsigned       IDLE_W     = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] LP_TO_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   LP_DEPTH   = (ADDR_W + 1)'(DEPTH_WORDS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_byte_cnt;
  logic [ADDR_W-1:0]   r_waddr;
  logic [IDLE_W-1:0]   r_idle;
  logic [ADDR_W:0]     r_len;
  logic [23:0]         r_word;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_word_done;
  logic                w_last_word;
  logic                w_timeout;
  logic [31:0]         w_full_word;
  logic                w_cpu_reset;
  logic                w_rx_ready;
  logic                w_busy;
  logic                w_done;
  logic                w_err;
  logic                w_pc_unused;

  assign w_accept    = bus.rx_valid && (r_state == ST_LOAD);
  assign w_len_ok    = (bus.load_len != '0) && (bus.load_len <= LP_DEPTH);
  assign w_start_ok  = bus.load_start && (r_state != ST_LOAD) && w_len_ok;
  assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
  assign w_last_word = w_word_done && (({1'b0, r_waddr} + (ADDR_W + 1)'(1)) == r_len);
  // An accepted byte in the expiry cycle wins, since it would clear the counter.
  assign w_timeout   = (r_state == ST_LOAD) && !w_accept && (r_idle == LP_TO_LAST);
  assign w_full_word = {r_word, bus.rx_data};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_reset = 1'b1;
    w_rx_ready  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_last_word) begin
          w_state_nxt = ST_RUN;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
        end
      end
      default: begin
        if (r_state == ST_RUN) begin
          w_cpu_reset = 1'b0;
          w_done      = 1'b1;
        end
        if (r_state == ST_ERR) begin
          w_err = 1'b1;
        end
        if (bus.load_start) begin
          w_state_nxt = w_len_ok ? ST_LOAD : ST_ERR;
        end
      end
    endcase
  end

  // Byte assembly, word address, idle counter and latched length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt <= '0;
      r_waddr    <= '0;
      r_idle     <= '0;
      r_len      <= '0;
      r_word     <= '0;
    end else if (w_start_ok) begin
      r_len      <= bus.load_len;
      r_byte_cnt <= '0;
      r_waddr    <= '0;
      r_idle     <= '0;
      r_word     <= '0;
    end else if (r_state == ST_LOAD) begin
      if (w_accept) begin
        r_idle     <= '0;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_word     <= {r_word[15:0], bus.rx_data};
        if (w_word_done) begin
          r_waddr <= r_waddr + ADDR_W'(1);
        end
      end else begin
        r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  // Memory write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_word_done) begin
      r_mem[r_waddr] <= w_full_word;
    end
  end

  assign bus.instr     = r_mem[bus.pc[ADDR_W+1:2]];
  assign bus.cpu_reset = w_cpu_reset;
  assign bus.rx_ready  = w_rx_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = w_err;

  // Byte-offset and high pc bits do not take part in the fetch address.
  assign w_pc_unused = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_imem_loader;

  localparam int unsigned AW = 6;

  localparam logic [4:0] S_IDLE = 5'b10000;
  localparam logic [4:0] S_LOAD = 5'b11100;
  localparam logic [4:0] S_RUN  = 5'b00010;
  localparam logic [4:0] S_ERR  = 5'b10001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(
    .DEPTH_WORDS(64),
    .ADDR_W     (AW),
    .TIMEOUT    (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    bit          is_instr;
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [4:0] status;
  assign status = {bus.cpu_reset, bus.rx_ready, bus.busy, bus.done, bus.err};

  // Monitor: compare every pending expectation at the falling edge
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c   = q.pop_front();
      act = c.is_instr ? bus.instr : {27'd0, status};
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_status(input string n, input logic [4:0] s);
    chk_t c;
    c.name     = n;
    c.is_instr = 1'b0;
    c.exp      = {27'd0, s};
    q.push_back(c);
  endtask

  task automatic exp_instr(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    bus.pc     = a;
    c.name     = n;
    c.is_instr = 1'b1;
    c.exp      = e;
    q.push_back(c);
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [AW:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  function automatic logic [31:0] wgen(input int unsigned i);
    logic [7:0] b;
    b = 8'(i);
    return {b, 8'hA5, ~b, 8'h3C};
  endfunction

  initial begin
    logic [31:0] w63;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.pc         = '0;

    repeat (3) @(posedge clk);
    #1;
    exp_status("reset_idle", S_IDLE);
    step();
    reset = 1'b1;
    step();
    exp_status("idle_after_release", S_IDLE);

    // Two-word load with rx_valid held high
    start(7'd2);
    exp_status("t1_load", S_LOAD);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hAC); send(8'h01); send(8'h00);
    exp_status("t1_before_last", S_LOAD);
    send(8'h04);
    bus.rx_valid = 1'b0;
    exp_status("t1_run", S_RUN);
    exp_instr("t1_mem0", 32'h0, 32'h20080005);
    exp_instr("t1_mem1", 32'h4, 32'hAC010004);
    exp_instr("wrap_0x100", 32'h100, 32'h20080005);
    exp_instr("wrap_pc_low_bits", 32'h106, 32'hAC010004);

    // Invalid lengths, recovery, load_start ignored during LOAD
    start(7'd0);
    exp_status("len0_err", S_ERR);
    start(7'd65);
    exp_status("len65_err", S_ERR);
    start(7'd1);
    exp_status("recover_load", S_LOAD);
    send(8'hDE); send(8'hAD);
    bus.load_start = 1'b1;
    bus.load_len   = 7'd0;
    send(8'hBE);
    bus.load_start = 1'b0;
    exp_status("start_ignored_in_load", S_LOAD);
    send(8'hEF);
    bus.rx_valid = 1'b0;
    exp_status("t2_run", S_RUN);
    exp_instr("t2_mem0", 32'h0, 32'hDEADBEEF);
    exp_instr("t2_mem1_kept", 32'h4, 32'hAC010004);

    // Reload from RUN
    start(7'd1);
    exp_status("reload_cpu_reset", S_LOAD);
    send_word(32'h01234567);
    bus.rx_valid = 1'b0;
    exp_status("reload_run", S_RUN);
    exp_instr("reload_mem0", 32'h0, 32'h01234567);
    exp_instr("reload_mem1_kept", 32'h4, 32'hAC010004);

    // Stalled source
    start(7'd1);
    send(8'hFF);
    bus.rx_valid = 1'b0;
    repeat (8) step();
    exp_status("stall_still_load", S_LOAD);
    for (int i = 0; i < 20 && !bus.err; i++) step();
    exp_status("timeout_err", S_ERR);
    exp_instr("timeout_mem0_kept", 32'h0, 32'h01234567);

    // Reset in the middle of the second word
    start(7'd2);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h44); send(8'h55); send(8'h66);
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    exp_status("reset_midload_idle", S_IDLE);
    exp_instr("reset_mem0_new", 32'h0, 32'h11223344);
    exp_instr("reset_mem1_kept", 32'h4, 32'hAC010004);
    reset = 1'b1;
    step();
    exp_status("idle_after_midload_reset", S_IDLE);

    // Full-depth load
    start(7'd64);
    exp_status("full_load", S_LOAD);
    for (int unsigned i = 0; i < 63; i++) send_word(wgen(i));
    w63 = wgen(63);
    send(w63[31:24]); send(w63[23:16]); send(w63[15:8]);
    exp_status("full_before_last", S_LOAD);
    send(w63[7:0]);
    bus.rx_valid = 1'b0;
    exp_status("full_run", S_RUN);
    exp_instr("full_mem0", 32'h0, wgen(0));
    exp_instr("full_mem32", 32'h80, wgen(32));
    exp_instr("full_mem63", 32'hFC, wgen(63));

    n_chk++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_done: got %b expected 1", bus.done);
    end
    n_chk++;
    if (bus.cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_cpu_reset: got %b expected 0", bus.cpu_reset);
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_busy: got %b expected 0", bus.busy);
    end
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_err: got %b expected 0", bus.err);
    end
    n_chk++;
    if (bus.instr !== wgen(63)) begin
      n_fail++;
      $display("FAIL direct_instr63: got %h expected %h", bus.instr, wgen(63));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

endmodule
